// File: rtl/piezo_tone_generator_if.sv
// Note-code / piezo-drive bundle between the ending-music sequencer (master) and the tone generator (slave).
// PIEZO_OCTAVE_SHIFT_EN adds the octave_up request line.
interface piezo_tone_generator_if;
  logic [3:0] note_code;
  logic       piezo;
  logic       tone_active;
  logic [3:0] note_cur;
  logic       code_err;
`ifdef PIEZO_OCTAVE_SHIFT_EN
  logic       octave_up;
`endif

  modport master (
`ifdef PIEZO_OCTAVE_SHIFT_EN
    output octave_up,
`endif
    output note_code,
    input  piezo, tone_active, note_cur, code_err
  );

  modport slave (
`ifdef PIEZO_OCTAVE_SHIFT_EN
    input  octave_up,
`endif
    input  note_code,
    output piezo, tone_active, note_cur, code_err
  );
endinterface

// File: rtl/piezo_tone_generator.sv
// Square-wave piezo driver for note codes 0 (rest) and 1..8 (C4..C5); pitch changes only on half-period boundaries.
// Optional macro PIEZO_OCTAVE_SHIFT_EN adds octave_up, halving the loaded half-period when high.
module piezo_tone_generator #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DIV_W  = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  piezo_tone_generator_if.slave bus_if
);

  localparam logic [DIV_W-1:0] HALF_C4 = DIV_W'(CLK_HZ / (2 * 262));
  localparam logic [DIV_W-1:0] HALF_D4 = DIV_W'(CLK_HZ / (2 * 294));
  localparam logic [DIV_W-1:0] HALF_E4 = DIV_W'(CLK_HZ / (2 * 330));
  localparam logic [DIV_W-1:0] HALF_F4 = DIV_W'(CLK_HZ / (2 * 349));
  localparam logic [DIV_W-1:0] HALF_G4 = DIV_W'(CLK_HZ / (2 * 392));
  localparam logic [DIV_W-1:0] HALF_A4 = DIV_W'(CLK_HZ / (2 * 440));
  localparam logic [DIV_W-1:0] HALF_B4 = DIV_W'(CLK_HZ / (2 * 494));
  localparam logic [DIV_W-1:0] HALF_C5 = DIV_W'(CLK_HZ / (2 * 523));

  typedef enum logic {IDLE, PLAY} state_t;

  function automatic logic [DIV_W-1:0] table_half(input logic [3:0] code);
    case (code)
      4'd1:    table_half = HALF_C4;
      4'd2:    table_half = HALF_D4;
      4'd3:    table_half = HALF_E4;
      4'd4:    table_half = HALF_F4;
      4'd5:    table_half = HALF_G4;
      4'd6:    table_half = HALF_A4;
      4'd7:    table_half = HALF_B4;
      4'd8:    table_half = HALF_C5;
      default: table_half = '0;
    endcase
  endfunction

  function automatic logic legal_code(input logic [3:0] code);
    return code <= 4'd8;
  endfunction

  state_t           state_q;
  logic [3:0]       note_q;
  logic [3:0]       code_prev_q;
  logic             code_err_q;
  logic             piezo_q;
  logic [3:0]       note_cur_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] half_q;
  logic [DIV_W-1:0] new_half;
  logic             at_bnd;
  logic             same_pitch;
  logic             load_en;

`ifdef PIEZO_OCTAVE_SHIFT_EN
  logic oct_q;
  logic oct_cur_q;

  always_comb begin
    new_half   = table_half(note_q) >> oct_q;
    same_pitch = (note_q == note_cur_q) && (oct_q == oct_cur_q);
  end

  // The octave request is tracked like note_q/note_cur_q so an octave-only change is a pitch change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oct_q     <= 1'b0;
      oct_cur_q <= 1'b0;
    end else begin
      oct_q <= bus_if.octave_up;
      if (load_en) oct_cur_q <= oct_q;
    end
  end
`else
  always_comb begin
    new_half   = table_half(note_q);
    same_pitch = (note_q == note_cur_q);
  end
`endif

  always_comb begin
    at_bnd  = (state_q == PLAY) && (cnt_q == half_q - DIV_W'(1));
    cnt_d   = at_bnd ? '0 : cnt_q + DIV_W'(1);
    load_en = (note_q != 4'd0) &&
              ((state_q == IDLE) || (at_bnd && !same_pitch));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      note_q      <= 4'd0;
      code_prev_q <= 4'd0;
      code_err_q  <= 1'b0;
      piezo_q     <= 1'b0;
      note_cur_q  <= 4'd0;
      cnt_q       <= '0;
      half_q      <= '0;
    end else begin
      note_q      <= legal_code(bus_if.note_code) ? bus_if.note_code : 4'd0;
      code_prev_q <= bus_if.note_code;
      code_err_q  <= !legal_code(bus_if.note_code) && (bus_if.note_code != code_prev_q);

      case (state_q)
        IDLE: begin
          piezo_q <= 1'b0;
          cnt_q   <= '0;
          if (load_en) begin
            piezo_q    <= 1'b1;
            half_q     <= new_half;
            note_cur_q <= note_q;
            state_q    <= PLAY;
          end
        end
        PLAY: begin
          cnt_q <= cnt_d;
          // Only the code sampled at the boundary matters; a rest lets the current level finish.
          if (at_bnd) begin
            if (note_q == 4'd0) begin
              piezo_q    <= 1'b0;
              note_cur_q <= 4'd0;
              state_q    <= IDLE;
            end else begin
              piezo_q <= ~piezo_q;
              if (load_en) begin
                half_q     <= new_half;
                note_cur_q <= note_q;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.piezo       = piezo_q;
  assign bus_if.tone_active = (state_q == PLAY);
  assign bus_if.note_cur    = note_cur_q;
  assign bus_if.code_err    = code_err_q;

endmodule

// File: tb/tb_piezo_tone_generator.sv
// Directed bench for piezo_tone_generator at CLK_HZ = 52400, which gives half-periods
// C4..C5 = 100, 89, 79, 75, 66, 59, 53, 50 cycles.
module tb_piezo_tone_generator;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  piezo_tone_generator_if bus();

  piezo_tone_generator #(.CLK_HZ(52400), .DIV_W(17)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Length of the piezo level currently showing, sampled from its first cycle.
  task automatic run_len(output int n);
    logic lv;
    lv = bus.piezo;
    n  = 0;
    while (bus.piezo === lv && n < 1000) begin
      tick(1);
      n++;
    end
  endtask

  task automatic go_idle();
    int n;
    bus.note_code = 4'd0;
    tick(1);
    n = 0;
    while (bus.tone_active !== 1'b0 && n < 1000) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL go_idle timeout tone_active=%b", bus.tone_active);
    end
  endtask

  task automatic start_note(input logic [3:0] code);
    go_idle();
    bus.note_code = code;
    tick(2);
    checks++;
    if (bus.piezo !== 1'b1) begin
      errors++;
      $display("FAIL start_note%0d piezo got %b exp 1", code, bus.piezo);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    bus.note_code = 4'd0;
    tick(3);
    checks++;
    if ({bus.piezo, bus.tone_active, bus.note_cur, bus.code_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state got %b exp 0", {bus.piezo, bus.tone_active, bus.note_cur, bus.code_err});
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (bus.piezo !== 1'b0 || bus.tone_active !== 1'b0 || bus.note_cur !== 4'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rest_1000 bad_cycles got %0d exp 0", bad);
    end
  endtask

  task automatic test_play_a4();
    int n;
    go_idle();
    bus.note_code = 4'd6;
    tick(1);
    checks++;
    if (bus.piezo !== 1'b0) begin
      errors++;
      $display("FAIL a4_latency1 piezo got %b exp 0", bus.piezo);
    end
    tick(1);
    checks++;
    if (bus.piezo !== 1'b1 || bus.tone_active !== 1'b1 || bus.note_cur !== 4'd6) begin
      errors++;
      $display("FAIL a4_rise got piezo=%b act=%b cur=%0d exp 1 1 6", bus.piezo, bus.tone_active, bus.note_cur);
    end
    run_len(n);
    checks++;
    if (n !== 59) begin errors++; $display("FAIL a4_high1 got %0d exp 59", n); end
    run_len(n);
    checks++;
    if (n !== 59) begin errors++; $display("FAIL a4_low1 got %0d exp 59", n); end
    run_len(n);
    checks++;
    if (n !== 59 || bus.note_cur !== 4'd6) begin
      errors++;
      $display("FAIL a4_high2 got len=%0d cur=%0d exp 59 6", n, bus.note_cur);
    end
  endtask

  task automatic test_note_change();
    int n;
    start_note(4'd1);
    tick(10);
    bus.note_code = 4'd8;
    run_len(n);
    checks++;
    if (n + 10 !== 100) begin errors++; $display("FAIL chg_high got %0d exp 100", n + 10); end
    checks++;
    if (bus.note_cur !== 4'd8) begin errors++; $display("FAIL chg_cur got %0d exp 8", bus.note_cur); end
    run_len(n);
    checks++;
    if (n !== 50) begin errors++; $display("FAIL chg_low got %0d exp 50", n); end
    run_len(n);
    checks++;
    if (n !== 50) begin errors++; $display("FAIL chg_high2 got %0d exp 50", n); end
  endtask

  task automatic test_return_same();
    int n;
    start_note(4'd1);
    tick(10);
    bus.note_code = 4'd2;
    tick(20);
    bus.note_code = 4'd1;
    run_len(n);
    checks++;
    if (n + 30 !== 100 || bus.note_cur !== 4'd1) begin
      errors++;
      $display("FAIL ret_high got len=%0d cur=%0d exp 100 1", n + 30, bus.note_cur);
    end
    run_len(n);
    checks++;
    if (n !== 100) begin errors++; $display("FAIL ret_low got %0d exp 100", n); end
  endtask

  task automatic test_rest_mid_high();
    int n;
    int bad;
    start_note(4'd3);
    tick(5);
    bus.note_code = 4'd0;
    run_len(n);
    checks++;
    if (n + 5 !== 79) begin errors++; $display("FAIL rest_high_len got %0d exp 79", n + 5); end
    checks++;
    if (bus.piezo !== 1'b0 || bus.tone_active !== 1'b0 || bus.note_cur !== 4'd0) begin
      errors++;
      $display("FAIL rest_high_edge got piezo=%b act=%b cur=%0d exp 0 0 0", bus.piezo, bus.tone_active, bus.note_cur);
    end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (bus.piezo !== 1'b0 || bus.tone_active !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rest_silent bad_cycles got %0d exp 0", bad); end
  endtask

  task automatic test_rest_mid_low();
    int n;
    int highs;
    start_note(4'd3);
    run_len(n);
    tick(5);
    bus.note_code = 4'd0;
    n = 0;
    highs = 0;
    while (bus.tone_active === 1'b1 && n < 1000) begin
      if (bus.piezo !== 1'b0) highs++;
      tick(1);
      n++;
    end
    checks++;
    if (n + 5 !== 79 || highs !== 0) begin
      errors++;
      $display("FAIL rest_low got len=%0d highs=%0d exp 79 0", n + 5, highs);
    end
    checks++;
    if (bus.piezo !== 1'b0 || bus.note_cur !== 4'd0) begin
      errors++;
      $display("FAIL rest_low_end got piezo=%b cur=%0d exp 0 0", bus.piezo, bus.note_cur);
    end
  endtask

  task automatic test_code_err();
    int pulses;
    int bad;
    go_idle();
    bus.note_code = 4'd12;
    pulses = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.code_err === 1'b1) pulses++;
      if (bus.piezo !== 1'b0 || bus.tone_active !== 1'b0 || bus.note_cur !== 4'd0) bad++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL err12_pulses got %0d exp 1", pulses); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL err12_silent bad_cycles got %0d exp 0", bad); end
    bus.note_code = 4'd13;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.code_err === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL err13_pulses got %0d exp 1", pulses); end
    bus.note_code = 4'd0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    int n;
    start_note(4'd5);
    tick(20);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.piezo, bus.tone_active, bus.note_cur} !== 6'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {bus.piezo, bus.tone_active, bus.note_cur});
    end
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++;
    if (bus.piezo !== 1'b0) begin errors++; $display("FAIL rel_latency1 piezo got %b exp 0", bus.piezo); end
    tick(1);
    checks++;
    if (bus.piezo !== 1'b1 || bus.note_cur !== 4'd5) begin
      errors++;
      $display("FAIL rel_rise got piezo=%b cur=%0d exp 1 5", bus.piezo, bus.note_cur);
    end
    run_len(n);
    checks++;
    if (n !== 66) begin errors++; $display("FAIL rel_high got %0d exp 66", n); end
  endtask

`ifdef PIEZO_OCTAVE_SHIFT_EN
  task automatic test_octave();
    int n;
    start_note(4'd6);
    tick(3);
    bus.octave_up = 1'b1;
    run_len(n);
    checks++;
    if (n + 3 !== 59) begin errors++; $display("FAIL oct_high got %0d exp 59", n + 3); end
    run_len(n);
    checks++;
    if (n !== 29) begin errors++; $display("FAIL oct_low got %0d exp 29", n); end
    bus.octave_up = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.note_code = 4'd0;
`ifdef PIEZO_OCTAVE_SHIFT_EN
    bus.octave_up = 1'b0;
`endif
    test_reset();
    test_play_a4();
    test_note_change();
    test_return_same();
    test_rest_mid_high();
    test_rest_mid_low();
    test_code_err();
    test_reset_mid();
`ifdef PIEZO_OCTAVE_SHIFT_EN
    test_octave();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piezo_tone_generator.md
Name: piezo_tone_generator

Overview:
Downstream stage of the ending-music sequencer. It consumes the 4-bit note code (0 = rest, 1..8 = C4..C5) and drives the piezo pin with a square wave at the note pitch. Pitch changes happen only on waveform half-period boundaries, so note changes are glitch-free. It also reports activity and rejects illegal codes.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- DIV_W, 17, half-period counter width; must hold CLK_HZ/(2*262)-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- note_code  in  4  0 = rest; 1..8 = C4 D4 E4 F4 G4 A4 B4 C5; 9..15 illegal
- piezo  out  1  square-wave drive
- tone_active  out  1  high while state is PLAY
- note_cur  out  4  code currently being sounded (0 when silent)
- code_err  out  1  one-cycle pulse when a new illegal code is first sampled

Behaviour:
- Pitch table: half = CLK_HZ/(2*F), integer division. F = 262, 294, 330, 349, 392, 440, 494, 523 Hz. At the default CLK_HZ this gives 95419, 85034, 75757, 71633, 63775, 56818, 50607, 47801.
- note_code is registered into note_q every cycle.
  - Illegal values are replaced by 0 (rest).
  - code_err pulses when the raw code is 9..15 and differs from its value on the previous cycle.
- State machine states: IDLE, PLAY.
- IDLE:
  - piezo = 0, cnt = 0.
  - If note_q != 0, next edge: piezo <= 1, cnt <= 0, half_r <= table(note_q), note_cur <= note_q, state <= PLAY.
  - Latency from a note_code change to the piezo rising edge is 2 clocks.
- PLAY:
  - cnt increments each cycle.
  - When cnt == half_r-1: cnt <= 0 and the boundary action below applies.
  - Every high and low level therefore lasts exactly half_r cycles.
- Boundary action in PLAY (cnt == half_r-1):
  - If note_q == note_cur: toggle piezo.
  - If note_q is a different nonzero code: toggle piezo, half_r <= table(note_q), note_cur <= note_q. The new pitch starts with the next level.
  - If note_q == 0 and piezo is high: piezo <= 0, note_cur <= 0, state <= IDLE.
  - If note_q == 0 and piezo is low: piezo stays 0, note_cur <= 0, state <= IDLE.
- Rest requested mid-level:
  - A high level always completes its full half_r cycles before going silent.
  - A low level also completes; no runt pulses occur.
- Note change followed by a return to the original code before the boundary: no change; only the value sampled at the boundary counts.
- tone_active = (state == PLAY). note_cur is registered.
- Reset (asynchronous, any time, including mid-level): state = IDLE, piezo = 0, cnt = 0, half_r = 0, note_cur = 0, note_q = 0, code_err = 0, tone_active = 0.
- Width rule: cnt and half_r are DIV_W bits. Table constants are computed at elaboration and truncated to DIV_W.

Optional Feature:
Macro: PIEZO_OCTAVE_SHIFT_EN
- Defined:
  - Adds input octave_up (1 bit), registered alongside note_code.
  - At every table load, half_r = table >> octave_up, i.e. one octave higher when high.
  - A change of octave_up alone with an unchanged note_code counts as a pitch change and is applied at the next boundary.
- Undefined: the port is absent and the table is used unshifted.

Test Plan:
- Reset, note_code=0 for 1000 cycles -> piezo=0, tone_active=0, note_cur=0 throughout.
- note_code=6 (A4) -> piezo rises 2 clocks later; high for 56818 cycles, low for 56818 cycles, repeating; note_cur=6.
- Playing code 1; switch to code 8 at cnt=10000 of a high level -> the high level still lasts 95419 cycles; following levels last 47801 cycles.
- Playing code 3, high level; note_code=0 at cnt=5 -> piezo stays high for the full 75757 cycles, then goes 0; tone_active falls on the same edge; stays silent.
- note_code=12 held for 50 cycles -> code_err high exactly 1 cycle; piezo stays 0; note_cur=0.
- Playing code 5; assert reset mid-level -> piezo, tone_active, note_cur go 0 immediately (asynchronously). Release with code 5 held -> piezo rises 2 clocks after reset deasserts.
